// File: rtl/io_pkg.sv
// Shared types and sizing helpers for the I/O issue responder.
// IO_WORD_IN_EN selects word-wide (XLEN/BYTE_W bytes) versus single-byte `in`.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    RX,
    DONE
  } io_state_t;

  function automatic int unsigned io_in_bytes(input int unsigned xlen, input int unsigned byte_w);
`ifdef IO_WORD_IN_EN
    return xlen / byte_w;
`else
    return 1;
`endif
  endfunction

  function automatic int unsigned io_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IN_BYTES = io_in_bytes(32, 8);
  localparam int unsigned CNT_W    = io_cnt_w(IN_BYTES);

endpackage

// File: rtl/io_word_assembler.sv
// Places received bytes into little-endian lanes of the `in` result.
// IO_WORD_IN_EN: multi-byte assembly with a lane counter; otherwise zero-extended single byte.
module io_word_assembler
  import io_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned NB     = io_in_bytes(XLEN, BYTE_W),
  parameter int unsigned CW     = io_cnt_w(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] rx_data,
  output logic [CW-1:0]     cnt,
  output logic              last,
  output logic [XLEN-1:0]   in_result
);

`ifdef IO_WORD_IN_EN
  logic [CW-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_result <= '0;
      cnt_q     <= '0;
    end else if (clear) begin
      in_result <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      in_result[cnt_q*BYTE_W +: BYTE_W] <= rx_data;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
  end
`else
  assign cnt  = '0;
  assign last = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_result <= '0;
    end else if (clear) begin
      in_result <= '0;
    end else if (load) begin
      in_result <= XLEN'(rx_data);
    end
  end
`endif

endmodule

// File: rtl/io_issue_unit.sv
// Stalls the pipeline while an `out` byte is sent or an `in` value is collected over the UART paths.
// IO_WORD_IN_EN (see io_pkg) widens `in` from one byte to XLEN/BYTE_W bytes.
module io_issue_unit
  import io_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_issued,
  input  logic              in_issued,
  input  logic [BYTE_W-1:0] out_data,
  output logic              stall,
  output logic [XLEN-1:0]   in_result,
  output logic              in_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned NB = io_in_bytes(XLEN, BYTE_W);
  localparam int unsigned CW = io_cnt_w(NB);

  io_state_t     state;
  logic          clear;
  logic          load;
  logic          last;
  logic          last_byte;
  logic [CW-1:0] cnt;

  // Issue flags only matter in IDLE; later states see the held instruction.
  assign stall = ((state == IDLE) && (out_issued || in_issued)) ||
                 (state == TX) || (state == RX);

  assign clear     = (state == IDLE) && !out_issued && in_issued;
  assign load      = (state == RX) && rx_ready && rx_valid;
  assign last_byte = last && (cnt == CW'(NB - 1));

  io_word_assembler #(
    .XLEN   (XLEN),
    .BYTE_W (BYTE_W),
    .NB     (NB),
    .CW     (CW)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (load),
    .rx_data   (rx_data),
    .cnt       (cnt),
    .last      (last),
    .in_result (in_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b0;
      in_valid <= 1'b0;
    end else begin
      in_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (out_issued) begin
            tx_data  <= out_data;
            tx_valid <= 1'b1;
            state    <= TX;
          end else if (in_issued) begin
            rx_ready <= 1'b1;
            state    <= RX;
          end
        end
        TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= DONE;
          end
        end
        RX: begin
          if (load && last_byte) begin
            rx_ready <= 1'b0;
            in_valid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_issue_unit.sv
// Randomized self-checking bench for io_issue_unit against a per-instruction transaction model.
module tb_io_issue_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BW   = 8;
`ifdef IO_WORD_IN_EN
  localparam int unsigned NB = XLEN / BW;
`else
  localparam int unsigned NB = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            out_issued = 1'b0;
  logic            in_issued = 1'b0;
  logic [BW-1:0]   out_data = '0;
  logic            tx_ready = 1'b0;
  logic [BW-1:0]   rx_data = '0;
  logic            rx_valid = 1'b0;
  logic            stall;
  logic [XLEN-1:0] in_result;
  logic            in_valid;
  logic [BW-1:0]   tx_data;
  logic            tx_valid;
  logic            rx_ready;

  io_issue_unit #(.XLEN(XLEN), .BYTE_W(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_issued (out_issued),
    .in_issued  (in_issued),
    .out_data   (out_data),
    .stall      (stall),
    .in_result  (in_result),
    .in_valid   (in_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready)
  );

  always #5 clk = ~clk;

  int unsigned     n_checks = 0;
  int unsigned     n_pass = 0;
  logic [7:0]      rx_byte [4];
  int unsigned     rx_gap  [4];
  logic [XLEN-1:0] last_res = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One instruction: issue, drive the UART side per schedule, and compare against the model.
  task automatic run_op(input bit is_out, input bit both, input logic [7:0] obyte,
                        input int unsigned w);
    bit              eff_out;
    bit              done;
    int unsigned     cyc, stalls, hs, ivp, wrong, bad_tx, k, gcnt, exp_stall;
    bit              pend;
    longint unsigned acc;
    logic [XLEN-1:0] exp_res;

    eff_out = is_out || both;
    done = 0; cyc = 0; stalls = 0; hs = 0; ivp = 0; wrong = 0; bad_tx = 0;
    k = 0; gcnt = 0; pend = 0; acc = 0;
    for (int i = 0; i < int'(NB); i++)
      acc = acc + longint'(rx_byte[i]) * (64'd1 << (8 * i));
    exp_res = eff_out ? last_res : XLEN'(acc);
    exp_stall = 2 + w;
    if (!eff_out) begin
      exp_stall = 1;
      for (int i = 0; i < int'(NB); i++) exp_stall += rx_gap[i] + 1;
    end

    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        out_issued = is_out || both;
        in_issued  = !is_out || both;
        out_data   = obyte;
      end
      if (eff_out) begin
        tx_ready = (cyc >= 1 + w);
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = 8'($urandom);
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
        if (cyc >= 1 && k < NB) begin
          rx_valid = (gcnt >= rx_gap[k]);
          rx_data  = rx_valid ? rx_byte[k] : 8'($urandom);
        end else begin
          rx_valid = 1'b0;
        end
      end
      #1;
      if (stall) stalls++;
      else done = 1;
      if (pend && !tx_valid && !(hs > 0)) bad_tx++;
      if (tx_valid && tx_data !== obyte) bad_tx++;
      if (eff_out) begin
        if (tx_valid && tx_ready) hs++;
        pend = tx_valid && !tx_ready;
        if (rx_ready) wrong++;
      end else begin
        if (rx_valid && rx_ready) begin
          hs++; k++; gcnt = 0;
        end else if (cyc >= 1) begin
          gcnt++;
        end
        if (tx_valid) wrong++;
      end
      if (in_valid) ivp++;
      if (done) check("in_valid_at_done", in_valid, !eff_out);
      cyc++;
    end

    check("op_done", done, 1);
    check("stall_len", stalls, exp_stall);
    check("handshakes", hs, eff_out ? 1 : NB);
    check("in_valid_pulses", ivp, eff_out ? 0 : 1);
    check("tx_stable", bad_tx, 0);
    check("other_side_idle", wrong, 0);
    check("in_result", in_result, exp_res);
    if (!eff_out) last_res = exp_res;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      out_issued = 0;
      in_issued  = 0;
      tx_ready   = 1'($urandom_range(0, 1));
      rx_valid   = 1'($urandom_range(0, 1));
      rx_data    = 8'($urandom);
      #1;
      check("idle_stall", stall, 0);
      check("idle_handshake_sides", {tx_valid, rx_ready, in_valid}, 0);
      check("idle_in_result_held", in_result, last_res);
    end
  endtask

  task automatic set_rx(input logic [31:0] word, input int unsigned max_gap);
    logic [31:0] wv;
    wv = word;
    for (int i = 0; i < 4; i++) begin
      rx_byte[i] = wv[8*i +: 8];
      rx_gap[i]  = $urandom_range(0, max_gap);
    end
  endtask

  initial begin
    int unsigned nfeed;
    logic [XLEN-1:0] exp_word;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("reset_outputs", {stall, tx_valid, tx_data, rx_ready, in_valid, in_result}, 0);
    idle(2);

    run_op(1, 0, 8'h41, 0);
    idle(1);
    run_op(1, 0, 8'h5A, 3);
    idle(1);

    set_rx(32'h12345678, 2);
    run_op(0, 0, 8'h00, 0);
`ifdef IO_WORD_IN_EN
    exp_word = 32'h12345678;
`else
    exp_word = 32'h00000078;
`endif
    check("in_word_value", in_result, exp_word);
    idle(1);

    set_rx(32'h000000F0, 0);
    run_op(0, 0, 8'h00, 0);
    idle(1);

    // back-to-back instructions, then both flags asserted together
    set_rx($urandom, 1);
    run_op(1, 0, 8'h99, 1);
    run_op(0, 0, 8'h00, 0);
    run_op(1, 0, 8'h3C, 0);
    run_op(1, 1, 8'hC3, 1);
    idle(1);

    // asynchronous reset in the middle of an `in`
    nfeed = (NB > 1) ? 2 : 0;
    @(posedge clk);
    #1 in_issued = 1; out_issued = 0; rx_valid = 0;
    for (int i = 0; i < int'(nfeed); i++) begin
      @(posedge clk);
      #1 rx_valid = 1; rx_data = 8'($urandom);
    end
    @(posedge clk);
    #1 rx_valid = 0;
    #2 rst_n = 0; in_issued = 0;
    #1 check("mid_reset_outputs", {stall, tx_valid, tx_data, rx_ready, in_valid, in_result}, 0);
    last_res = '0;
    repeat (2) @(posedge clk);
    #1 check("in_reset_no_pulse", {in_valid, tx_valid}, 0);
    rst_n = 1;
    set_rx(32'hA1B2C3D4, 1);
    run_op(0, 0, 8'h00, 0);
    idle(1);

    for (int t = 0; t < 40; t++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      set_rx($urandom, 3);
      run_op(kind != 1, kind == 3, 8'($urandom), $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_issue_unit.md
# io_issue_unit

Responder for the `out_issued` / `in_issued` flags that the pipeline control decoder produces for the custom I/O instructions. It sits beside the execute stage and holds the pipeline with `stall` while an `out` byte is handed to the UART transmit path or an `in` value is collected from the UART receive path. On an `in`, it returns the assembled result for writeback.

## Interface
Parameters:
- `XLEN`, default 32: width of the register-file value returned by `in`.
- `BYTE_W`, default 8: width of one UART byte.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `out_issued`  in  1  the execute-stage instruction is `out`. Already qualified: valid, not flushed.
- `in_issued`  in  1  the execute-stage instruction is `in`. Already qualified.
- `out_data`  in  `BYTE_W`  low byte of rs2 for `out`.
- `stall`  out  1  hold the pipeline at the execute stage and upstream.
- `in_result`  out  `XLEN`  value to write to rd for `in`.
- `in_valid`  out  1  one-cycle pulse; `in_result` is valid for writeback.
- `tx_data`  out  `BYTE_W`  byte to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the transmitter accepts the byte.
- `rx_data`  in  `BYTE_W`  byte from the receive FIFO.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  this unit consumes `rx_data`.

## Operation
States: IDLE, TX, RX, DONE.
- **IDLE**
  - `out_issued` → latch `out_data` into `tx_data`; next state TX.
  - Otherwise `in_issued` → clear `in_result` to 0 and the byte counter to 0; next state RX.
  - If both flags are high (illegal), `out` wins.
- **TX**
  - `tx_valid`=1, `tx_data` stable.
  - `tx_valid && tx_ready` → DONE.
- **RX**
  - `rx_ready`=1.
  - `rx_valid && rx_ready` → write `rx_data` into byte lane `cnt` of `in_result`, little-endian.
  - Last byte → DONE; otherwise `cnt`++.
- **DONE**
  - `stall`=0, so the pipeline advances at the end of this cycle.
  - `in_valid`=1 only if the completed op was `in`.
  - Issue flags are ignored in this state, because they still show the completing instruction.
  - Next state IDLE.
- `stall` = (IDLE && (`out_issued` || `in_issued`)) || TX || RX. It is combinational from the issue flags in IDLE and registered-state-based otherwise.
- Issue flags are ignored outside IDLE; the held instruction keeps them asserted.
- `in_result` holds its value after DONE until the next `in` starts.
- Reset asserted mid-operation → IDLE immediately. Partial bytes are discarded, and no pulse is produced on `tx_valid` or `in_valid`.

## Timing
- Reset values: `stall`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `in_valid`=0, `in_result`=0, state IDLE, `cnt`=0.
- `out` with `tx_ready` held high:
  - issue cycle C0: `stall`=1;
  - C1: TX handshake;
  - C2: DONE, `stall`=0.
  - Minimum of 2 stalled cycles.
- `in` with `rx_valid` held high: C0 issue, C1..CN byte handshakes with N = bytes per `in`, CN+1 DONE with `in_valid`=1.
- Backpressure: every wait cycle on `tx_ready` or `rx_valid` extends `stall` by one cycle. There is no timeout.
- `tx_valid` never drops before `tx_ready`. `tx_data` does not change while `tx_valid`=1.
- Back-to-back I/O instructions: the second is seen in the cycle after DONE and stalls from that cycle.

## Configuration
- `IO_WORD_IN_EN` defined:
  - `in` consumes `XLEN/BYTE_W` bytes (4 by default), assembled little-endian; the first byte lands in bits [7:0].
- Undefined:
  - `in` consumes one byte, zero-extended to `XLEN`.
  - The counter logic is compiled out; RX → DONE on the first handshake.

## Structure
- Shared package `io_pkg`:
  - `io_state_t` enum {IDLE, TX, RX, DONE};
  - localparam `IN_BYTES` = `XLEN/BYTE_W` or 1, selected by the macro;
  - counter width `$clog2(IN_BYTES)` with a minimum of 1.
- One sub-module, `io_word_assembler`, owns byte-lane placement:
  - `clear` input;
  - `load` input with `rx_data`;
  - `cnt` and `last` outputs;
  - the registered `in_result`.
- The FSM stays in `io_issue_unit`.

## Test plan
- Reset check: after reset release, all outputs are 0. `out_issued`=1, `out_data`=0x41, `tx_ready`=1 → `stall`=1 for 2 cycles, `tx_valid`=1 with `tx_data`=0x41 for 1 cycle, then `stall`=0 for one cycle.
- `out` with backpressure: `tx_ready` low for 3 cycles → `tx_valid` and `tx_data` stable throughout, `stall` lasts 5 cycles, exactly one handshake.
- `in` with the macro defined: bytes 0x78, 0x56, 0x34, 0x12 arrive with gaps of 0–2 cycles → `in_result`=0x12345678 and `in_valid` pulses once in the cycle `stall` drops.
- `in` with the macro undefined: byte 0xF0 → `in_result`=0x000000F0 after 1 handshake, 3 cycles total.
- Back-to-back and priority:
  - `out` then `in` in consecutive instructions → no lost or duplicated handshakes;
  - both flags high in IDLE → `out` executed.
- Reset mid-`in` after 2 bytes:
  - all outputs return to 0 asynchronously and no `in_valid` is produced;
  - a following `in` assembles cleanly from lane 0.
